// File: rtl/intersection_ctrl.sv
// Two-road intersection scheduler: NS main road rests green, EW side road and an
// optional pedestrian WALK phase (enabled by INTERSECTION_PED_EN) are served on demand.
module intersection_ctrl #(
    parameter int unsigned GREEN_TIME  = 15,
    parameter int unsigned YELLOW_TIME = 5,
    parameter int unsigned ALLRED_TIME = 2,
    parameter int unsigned WALK_TIME   = 8
) (
    input  logic       div_clk,
    input  logic       reset,
    input  logic       sensor_ew,
    input  logic       ped_req,
    output logic [1:0] ns_status,
    output logic [1:0] ew_status,
    output logic [3:0] value,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR_A = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        AR_B = 3'd5
`ifdef INTERSECTION_PED_EN
        , WALK = 3'd6
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] value_q, value_d;
    logic [1:0]       ns_q, ew_q;
    logic             ew_pend_q;
    logic             ped_pend_q;

    // Countdown load for the state being entered.
    function automatic logic [CNT_W-1:0] dur(input state_e s);
        case (s)
            NS_G, EW_G: dur = CNT_W'(GREEN_TIME);
            NS_Y, EW_Y: dur = CNT_W'(YELLOW_TIME);
            AR_A, AR_B: dur = CNT_W'(ALLRED_TIME);
`ifdef INTERSECTION_PED_EN
            WALK:       dur = CNT_W'(WALK_TIME);
`endif
            default:    dur = CNT_W'(GREEN_TIME);
        endcase
    endfunction

    // Light codes {ns, ew}: 0 green, 1 yellow, 2 red.
    function automatic logic [3:0] lights(input state_e s);
        case (s)
            NS_G:    lights = {2'd0, 2'd2};
            NS_Y:    lights = {2'd1, 2'd2};
            EW_G:    lights = {2'd2, 2'd0};
            EW_Y:    lights = {2'd2, 2'd1};
            default: lights = {2'd2, 2'd2};
        endcase
    endfunction

    // Next-state: count down, decide only when the count has reached zero.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        if (value_q != '0) begin
            value_d = value_q - CNT_W'(1);
        end else begin
            case (state_q)
                NS_G: if (ew_pend_q || ped_pend_q) state_d = NS_Y;
                NS_Y: state_d = AR_A;
`ifdef INTERSECTION_PED_EN
                AR_A: state_d = ew_pend_q ? EW_G : WALK;
                AR_B: state_d = ped_pend_q ? WALK : NS_G;
                WALK: state_d = NS_G;
`else
                AR_A: state_d = EW_G;
                AR_B: state_d = NS_G;
`endif
                EW_G: state_d = EW_Y;
                EW_Y: state_d = AR_B;
                default: state_d = NS_G;
            endcase
            if (state_d != state_q) value_d = dur(state_d);
        end
    end

    always_ff @(posedge div_clk) begin
        if (reset) begin
            state_q   <= NS_G;
            value_q   <= CNT_W'(GREEN_TIME);
            ns_q      <= 2'd0;
            ew_q      <= 2'd2;
            ew_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            {ns_q, ew_q} <= lights(state_d);
            // A request on the edge that grants EW is absorbed by that grant.
            if (state_d == EW_G && state_q != EW_G) ew_pend_q <= 1'b0;
            else if (sensor_ew && state_q != EW_G)  ew_pend_q <= 1'b1;
        end
    end

`ifdef INTERSECTION_PED_EN
    logic walk_q, ack_q;

    always_ff @(posedge div_clk) begin
        if (reset) begin
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            walk_q <= (state_d == WALK);
            ack_q  <= (state_d == WALK) && (state_q != WALK);
            if (state_d == WALK && state_q != WALK) ped_pend_q <= 1'b0;
            else if (ped_req && state_q != WALK)    ped_pend_q <= 1'b1;
        end
    end

    assign walk    = walk_q;
    assign ped_ack = ack_q;
`else
    logic [CNT_W:0] unused_c;

    assign unused_c   = {ped_req, CNT_W'(WALK_TIME)};
    assign ped_pend_q = 1'b0;
    assign walk       = 1'b0;
    assign ped_ack    = 1'b0;
`endif

    assign ns_status = ns_q;
    assign ew_status = ew_q;
    assign value     = value_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed self-checking bench for intersection_ctrl; expected phase/value per cycle
// come from hand-written segment tables (start cycle, phase code, load).
module tb_intersection_ctrl;

    logic       div_clk = 1'b0;
    logic       reset = 1'b0;
    logic       sensor_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] ns_status, ew_status;
    logic [3:0] value;
    logic       walk, ped_ack;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef int seg_t [8];

    intersection_ctrl dut (
        .div_clk   (div_clk),
        .reset     (reset),
        .sensor_ew (sensor_ew),
        .ped_req   (ped_req),
        .ns_status (ns_status),
        .ew_status (ew_status),
        .value     (value),
        .walk      (walk),
        .ped_ack   (ped_ack),
        .phase     (phase)
    );

    always #5 div_clk = ~div_clk;

    task automatic step();
        @(posedge div_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset     = 1'b0;
        sensor_ew = 1'b0;
        ped_req   = 1'b0;
        cyc       = 0;
    endtask

    function automatic void exp_at(input seg_t st, input seg_t ph, input seg_t ld,
                                   input int n, input int k, output int eph, output int ev);
        eph = 0;
        ev  = 0;
        for (int i = 0; i < n; i++) begin
            if (k >= st[i]) begin
                eph = ph[i];
                ev  = ld[i] - (k - st[i]);
                if (ev < 0) ev = 0;
            end
        end
    endfunction

    function automatic logic [3:0] exp_lights(input int eph);
        case (eph)
            0:       return {2'd0, 2'd2};
            1:       return {2'd1, 2'd2};
            3:       return {2'd2, 2'd0};
            4:       return {2'd2, 2'd1};
            default: return {2'd2, 2'd2};
        endcase
    endfunction

    task automatic test_reset();
        seg_t st = '{0, 0, 0, 0, 0, 0, 0, 0};
        seg_t ph = '{0, 0, 0, 0, 0, 0, 0, 0};
        seg_t ld = '{15, 0, 0, 0, 0, 0, 0, 0};
        int eph, ev;
        logic [3:0] el;
        do_reset();
        while (cyc <= 40) begin
            exp_at(st, ph, ld, 1, cyc, eph, ev);
            el = exp_lights(eph);
            total++;
            if (phase !== 3'(eph) || value !== 4'(ev) || {ns_status, ew_status} !== el
                || walk !== 1'b0 || ped_ack !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d phase=%0d want %0d value=%0d want %0d ns/ew=%0d/%0d want %0d/%0d walk=%b ack=%b",
                         cyc, phase, eph, value, ev, ns_status, ew_status, el[3:2], el[1:0], walk, ped_ack);
            end
            step();
        end
    endtask

    task automatic test_ew();
        seg_t st = '{0, 16, 22, 25, 41, 47, 50, 0};
        seg_t ph = '{0, 1, 2, 3, 4, 5, 0, 0};
        seg_t ld = '{15, 5, 2, 15, 5, 2, 15, 0};
        int eph, ev;
        logic [3:0] el;
        do_reset();
        while (cyc <= 66) begin
            exp_at(st, ph, ld, 7, cyc, eph, ev);
            el = exp_lights(eph);
            total++;
            if (phase !== 3'(eph) || value !== 4'(ev) || {ns_status, ew_status} !== el
                || walk !== 1'b0 || ped_ack !== 1'b0) begin
                bad++;
                $display("FAIL ew_cycle cyc=%0d phase=%0d want %0d value=%0d want %0d ns/ew=%0d/%0d want %0d/%0d walk=%b ack=%b",
                         cyc, phase, eph, value, ev, ns_status, ew_status, el[3:2], el[1:0], walk, ped_ack);
            end
            sensor_ew = (cyc == 3);
            step();
        end
        sensor_ew = 1'b0;
    endtask

    task automatic test_late_request();
        seg_t st = '{0, 17, 23, 26, 0, 0, 0, 0};
        seg_t ph = '{0, 1, 2, 3, 0, 0, 0, 0};
        seg_t ld = '{15, 5, 2, 15, 0, 0, 0, 0};
        int eph, ev;
        logic [3:0] el;
        do_reset();
        while (cyc <= 30) begin
            exp_at(st, ph, ld, 4, cyc, eph, ev);
            el = exp_lights(eph);
            total++;
            if (phase !== 3'(eph) || value !== 4'(ev) || {ns_status, ew_status} !== el) begin
                bad++;
                $display("FAIL late_request cyc=%0d phase=%0d want %0d value=%0d want %0d ns/ew=%0d/%0d want %0d/%0d",
                         cyc, phase, eph, value, ev, ns_status, ew_status, el[3:2], el[1:0]);
            end
            sensor_ew = (cyc == 15);
            step();
        end
        sensor_ew = 1'b0;
    endtask

    task automatic test_reset_mid();
        seg_t st = '{0, 16, 22, 25, 0, 0, 0, 0};
        seg_t ph = '{0, 1, 2, 3, 0, 0, 0, 0};
        seg_t ld = '{15, 5, 2, 15, 0, 0, 0, 0};
        int eph, ev;
        logic [3:0] el;
        do_reset();
        while (cyc <= 33) begin
            exp_at(st, ph, ld, 4, cyc, eph, ev);
            el = exp_lights(eph);
            total++;
            if (phase !== 3'(eph) || value !== 4'(ev) || {ns_status, ew_status} !== el) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d phase=%0d want %0d value=%0d want %0d ns/ew=%0d/%0d want %0d/%0d",
                         cyc, phase, eph, value, ev, ns_status, ew_status, el[3:2], el[1:0]);
            end
            sensor_ew = (cyc == 3);
            if (cyc < 33) step();
            else break;
        end
        // Abort EW_G at value 7; a pulse in the same cycle must be dropped by reset.
        sensor_ew = 1'b1;
        do_reset();
        total++;
        if (phase !== 3'd0 || value !== 4'd15 || ns_status !== 2'd0 || ew_status !== 2'd2
            || walk !== 1'b0 || ped_ack !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset phase=%0d want 0 value=%0d want 15 ns/ew=%0d/%0d want 0/2 walk=%b ack=%b",
                     phase, value, ns_status, ew_status, walk, ped_ack);
        end
        // Pending request raised then wiped by reset must not leave NS_G.
        while (cyc <= 8) begin
            sensor_ew = (cyc == 3);
            if (cyc == 5) break;
            step();
        end
        sensor_ew = 1'b0;
        do_reset();
        while (cyc <= 25) begin
            total++;
            if (phase !== 3'd0 || value !== 4'(cyc <= 15 ? 15 - cyc : 0) || ns_status !== 2'd0) begin
                bad++;
                $display("FAIL pend_cleared cyc=%0d phase=%0d want 0 value=%0d want %0d ns=%0d want 0",
                         cyc, phase, value, (cyc <= 15 ? 15 - cyc : 0), ns_status);
            end
            step();
        end
    endtask

`ifdef INTERSECTION_PED_EN
    task automatic test_ped();
        seg_t st = '{0, 16, 22, 25, 34, 0, 0, 0};
        seg_t ph = '{0, 1, 2, 6, 0, 0, 0, 0};
        seg_t ld = '{15, 5, 2, 8, 15, 0, 0, 0};
        int eph, ev;
        logic [3:0] el;
        do_reset();
        while (cyc <= 52) begin
            exp_at(st, ph, ld, 5, cyc, eph, ev);
            el = exp_lights(eph);
            total++;
            if (phase !== 3'(eph) || value !== 4'(ev) || {ns_status, ew_status} !== el
                || walk !== (eph == 6) || ped_ack !== (cyc == 25)) begin
                bad++;
                $display("FAIL ped_only cyc=%0d phase=%0d want %0d value=%0d want %0d ns/ew=%0d/%0d want %0d/%0d walk=%b ack=%b",
                         cyc, phase, eph, value, ev, ns_status, ew_status, el[3:2], el[1:0], walk, ped_ack);
            end
            ped_req = (cyc == 3);
            step();
        end
        ped_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        seg_t st = '{0, 16, 22, 25, 41, 47, 50, 59};
        seg_t ph = '{0, 1, 2, 3, 4, 5, 6, 0};
        seg_t ld = '{15, 5, 2, 15, 5, 2, 8, 15};
        int eph, ev;
        logic [3:0] el;
        do_reset();
        while (cyc <= 80) begin
            exp_at(st, ph, ld, 8, cyc, eph, ev);
            el = exp_lights(eph);
            total++;
            if (phase !== 3'(eph) || value !== 4'(ev) || {ns_status, ew_status} !== el
                || walk !== (eph == 6) || ped_ack !== (cyc == 50)) begin
                bad++;
                $display("FAIL both_demands cyc=%0d phase=%0d want %0d value=%0d want %0d ns/ew=%0d/%0d want %0d/%0d walk=%b ack=%b",
                         cyc, phase, eph, value, ev, ns_status, ew_status, el[3:2], el[1:0], walk, ped_ack);
            end
            sensor_ew = (cyc == 3);
            ped_req   = (cyc == 3) || (cyc == 52);
            step();
        end
        sensor_ew = 1'b0;
        ped_req   = 1'b0;
    endtask
`else
    task automatic test_ped_disabled();
        do_reset();
        ped_req = 1'b1;
        while (cyc <= 100) begin
            total++;
            if (phase !== 3'd0 || value !== 4'(cyc <= 15 ? 15 - cyc : 0) || walk !== 1'b0
                || ped_ack !== 1'b0 || ns_status !== 2'd0 || ew_status !== 2'd2) begin
                bad++;
                $display("FAIL ped_disabled cyc=%0d phase=%0d want 0 value=%0d want %0d walk=%b ack=%b ns/ew=%0d/%0d",
                         cyc, phase, value, (cyc <= 15 ? 15 - cyc : 0), walk, ped_ack, ns_status, ew_status);
            end
            step();
        end
        ped_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_ew();
        test_late_request();
        test_reset_mid();
`ifdef INTERSECTION_PED_EN
        test_ped();
        test_back_to_back();
`else
        test_ped_disabled();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Two-road intersection scheduler that shares the crossing between a main road (NS) and a side road (EW), with an optional pedestrian walk phase. It drives one light-status code per road and a shared phase countdown, and it runs on the divided one-second tick clock. It replaces a free-running single-light sequencer at the top of the traffic-light design, granting the crossing only on demand and always separating conflicting greens with an all-red interval.

## Interface
- GREEN_TIME, 15, NS and EW green countdown load (0..15)
- YELLOW_TIME, 5, yellow countdown load (0..15)
- ALLRED_TIME, 2, all-red clearance countdown load (0..15)
- WALK_TIME, 8, pedestrian walk countdown load (0..15)
- div_clk  in  1  divided tick clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of div_clk
- sensor_ew  in  1  side-road vehicle present (level or pulse)
- ped_req  in  1  pedestrian button (level or pulse)
- ns_status  out  2  NS light: 0 GREEN, 1 YELLOW, 2 RED (3 never driven)
- ew_status  out  2  EW light, same encoding
- value  out  4  remaining count of the current phase
- walk  out  1  walk lamp; high only in WALK
- ped_ack  out  1  one-cycle pulse on entry to WALK
- phase  out  3  current state code, debug only

## Operation
- States (phase code): NS_G=0, NS_Y=1, AR_A=2, EW_G=3, EW_Y=4, AR_B=5, WALK=6.
- Lights per state: NS_G gives NS GREEN/EW RED. NS_Y gives NS YELLOW/EW RED. EW_G gives NS RED/EW GREEN. EW_Y gives NS RED/EW YELLOW. AR_A, AR_B and WALK give RED/RED.
- Countdown: entering a state loads its duration into value. NS_G and EW_G load GREEN_TIME, yellows load YELLOW_TIME, all-reds load ALLRED_TIME, WALK loads WALK_TIME. While value != 0, value decrements by 1 each cycle. The state transitions on the cycle where value == 0, so a state loaded with N lasts N+1 cycles. The counter never wraps below 0.
- ew_pending: set by sensor_ew=1 in any state except EW_G. Cleared on the edge entering EW_G, and a sensor_ew high on that same edge is absorbed.
- ped_pending: set by ped_req=1 in any state except WALK. Cleared on the edge entering WALK, and a ped_req high on that same edge is absorbed. ped_req is ignored during WALK.
- Transitions taken at value == 0:
  - NS_G: go to NS_Y if ew_pending or ped_pending. Otherwise hold NS_G with value held at 0 (main-road rest).
  - NS_Y goes to AR_A.
  - AR_A: go to EW_G if ew_pending, else go to WALK.
  - EW_G goes to EW_Y, then AR_B.
  - AR_B: go to WALK if ped_pending, else go to NS_G.
  - WALK goes to NS_G.
- The pending flags use the values registered before the edge. A request arriving in the decision cycle itself is not seen until the next decision.
- ped_ack=1 for exactly the first cycle of each WALK visit.

## Timing
- Reset (reset=1 at an edge) gives state NS_G, ns_status=0, ew_status=2, value=GREEN_TIME, walk=0, ped_ack=0, phase=0, both pending flags 0. Reset overrides every other input.
- Reset mid-phase (including WALK or a yellow) aborts that phase immediately. No yellow or all-red is inserted.
- All outputs are registered or decoded only from registered state. Input-to-output latency is one div_clk edge for the pending flags and at least one further edge for any light change.
- Full cycle with both demands and default parameters: 16+6+3+16+6+3+9 = 59 cycles.

## Configuration
- INTERSECTION_PED_EN defined: WALK state, ped_pending, walk and ped_ack behave as described above.
- INTERSECTION_PED_EN undefined:
  - ped_pending is a constant 0 and ped_req is unused.
  - walk=0 and ped_ack=0 always.
  - AR_A always goes to EW_G; NS_G leaves only on ew_pending.
  - The WALK state is removed from the FSM.

## Test plan
- Reset, no requests for 40 cycles: outputs stay ns=0, ew=2, and value counts 15..0 then holds 0. phase stays 0 throughout.
- sensor_ew pulse at cycle 3 after reset: NS_Y is entered at cycle 16 with value=5. AR_A follows at 22, EW_G at 25 with value=15, EW_Y at 41, AR_B at 47 and NS_G at 50. walk stays 0 throughout.
- ped_req pulse only, macro defined: sequence is NS_G, NS_Y, AR_A, then WALK with value=8, walk=1 and a one-cycle ped_ack, then NS_G. EW never goes green.
- Both sensor_ew and ped_req pulsed in NS_G: sequence is EW_G, EW_Y, AR_B, WALK, NS_G. A ped_req re-asserted during WALK produces no second WALK.
- Reset asserted for one cycle at EW_G value=7: the next cycle shows ns=0, ew=2, value=15, pendings cleared.
- Macro undefined, ped_req held high for 100 cycles: controller stays in NS_G with walk=0 and ped_ack=0.
